fir_coef_loader: RTL

- Sequences coefficient reload for the systolic FIR tap chain.
- Accepts a stream of TAPS coefficients over a valid/ready handshake and shifts them serially into the shadow coefficient chain that feeds the taps' inCoef inputs.
- Once the chain is complete, issues a single bank-swap pulse aligned to a sample boundary, so the datapath never filters with a mixed coefficient set.
- Sits between the control/AXI register block and the tap chain.

---
 rtl/fir_coef_loader.sv | 115 +++++++++++
 1 files changed

// File: rtl/fir_coef_loader.sv
// Serial coefficient loader for the FIR shadow bank, with a sample-aligned bank swap.
// Latency: beat to coef_sh_en is 1 cycle; swap/done come 1 cycle after the first sample_tick seen in WAIT_SWAP.
// Backpressure: s_coef_ready is high only in LOAD. Optional running checksum output when FIR_COEF_CHECKSUM_EN is defined.
module fir_coef_loader #(
    parameter int TAPS  = 16,
    parameter int COEFW = 18,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_tick,
    input  logic [COEFW-1:0] s_coef_data,
    input  logic             s_coef_valid,
    input  logic             s_coef_last,
    output logic             s_coef_ready,
    output logic [COEFW-1:0] coef_sh_data,
    output logic             coef_sh_en,
    output logic             swap,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef FIR_COEF_CHECKSUM_EN
    ,
    output logic [COEFW+CNTW-1:0] checksum
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_SWAP, ERR} state_t;

    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(TAPS - 1);

    state_t          state, state_nx;
    logic [CNTW-1:0] cnt, cnt_nx;
    logic            accept;
    logic            start_acc;
    logic            swap_nx;

    assign s_coef_ready = (state == LOAD);
    assign busy         = (state == LOAD) || (state == WAIT_SWAP);
    assign err          = (state == ERR);
    assign accept       = s_coef_valid && s_coef_ready;
    assign start_acc    = start && ((state == IDLE) || (state == ERR));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Framing is judged on the beat carrying index TAPS-1 or the last flag, whichever comes first.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        swap_nx  = 1'b0;
        case (state)
            IDLE, ERR: begin
                if (start_acc) begin
                    state_nx = LOAD;
                    cnt_nx   = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    cnt_nx = cnt + CNTW'(1);
                    if (cnt == LAST_IDX) begin
                        state_nx = s_coef_last ? WAIT_SWAP : ERR;
                    end else if (s_coef_last) begin
                        state_nx = ERR;
                    end
                end
            end
            WAIT_SWAP: begin
                if (sample_tick) begin
                    swap_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coef_sh_en   <= 1'b0;
            coef_sh_data <= '0;
            swap         <= 1'b0;
            done         <= 1'b0;
        end else begin
            coef_sh_en <= accept;
            if (accept) begin
                coef_sh_data <= s_coef_data;
            end
            swap <= swap_nx;
            done <= swap_nx;
        end
    end

`ifdef FIR_COEF_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if (start_acc) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + {{CNTW{s_coef_data[COEFW-1]}}, s_coef_data};
        end
    end
`endif

endmodule
